// File: rtl/scr1_dmi_tracker_pkg.sv
// Shared types and constants for the SCR1 DMI tracker: status/op encodings,
// request FSM states, TAP chain IDs and DTMCS field positions.
package scr1_dmi_pkg;

  typedef enum logic [1:0] {
    OK     = 2'd0,
    FAILED = 2'd2,
    BUSY   = 2'd3
  } type_scr1_dmi_stat_e;

  typedef enum logic [1:0] {
    NOP = 2'd0,
    RD  = 2'd1,
    WR  = 2'd2,
    RSV = 2'd3
  } type_scr1_dmi_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } type_scr1_dmi_fsm_e;

  localparam logic [1:0] DTMCS = 2'd1;
  localparam logic [1:0] DMI   = 2'd2;

  localparam int unsigned DTMCS_W             = 32;
  localparam int unsigned DTMCS_VERSION_LSB   = 0;
  localparam int unsigned DTMCS_ABITS_LSB     = 4;
  localparam int unsigned DTMCS_STAT_LSB      = 10;
  localparam int unsigned DTMCS_IDLE_LSB      = 12;
  localparam int unsigned DTMCS_DMIRESET_BIT  = 16;
  localparam int unsigned DTMCS_HARDRESET_BIT = 17;

endpackage

// File: rtl/scr1_dmi_tracker_if.sv
// DMI-to-DM request/response bus.
interface scr1_dmi_tracker_if #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 32
);
  // Handshake: req is held with wr/addr/wdata stable until the DM pulses resp
  // for one cycle; resp is only meaningful while req=1, err and rdata are
  // qualified by resp (rdata only for reads). req drops the cycle after resp.
  logic                  dmi2dm_req_o;
  logic                  dmi2dm_wr_o;
  logic [ADDR_WIDTH-1:0] dmi2dm_addr_o;
  logic [DATA_WIDTH-1:0] dmi2dm_wdata_o;
  logic                  dm2dmi_resp_i;
  logic                  dm2dmi_err_i;
  logic [DATA_WIDTH-1:0] dm2dmi_rdata_i;

  modport master (
    output dmi2dm_req_o, dmi2dm_wr_o, dmi2dm_addr_o, dmi2dm_wdata_o,
    input  dm2dmi_resp_i, dm2dmi_err_i, dm2dmi_rdata_i
  );

  modport slave (
    input  dmi2dm_req_o, dmi2dm_wr_o, dmi2dm_addr_o, dmi2dm_wdata_o,
    output dm2dmi_resp_i, dm2dmi_err_i, dm2dmi_rdata_i
  );
endinterface

// File: rtl/scr1_dmi_req_fsm.sv
// IDLE/REQ request tracker toward the DM: request registers, timeout counter,
// read-data capture and sticky dmistat.
module scr1_dmi_req_fsm
  import scr1_dmi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  scr1_dmi_tracker_if.master    dm,
  input  logic                  dmi_capture,
  input  logic                  dmi_update,
  input  type_scr1_dmi_op_e     upd_op,
  input  logic [ADDR_WIDTH-1:0] upd_addr,
  input  logic [DATA_WIDTH-1:0] upd_data,
  input  logic                  dmireset,
  input  logic                  dmihardreset,
  output type_scr1_dmi_fsm_e    state,
  output logic [1:0]            dmistat,
  output logic [ADDR_WIDTH-1:0] last_addr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  type_scr1_dmi_fsm_e    state_ff, state_next;
  type_scr1_dmi_stat_e   stat_ff, stat_next;
  logic [CNT_W-1:0]      cnt_ff;
  logic                  wr_ff;
  logic [ADDR_WIDTH-1:0] addr_ff;
  logic [DATA_WIDTH-1:0] wdata_ff;
  logic [DATA_WIDTH-1:0] rdata_ff;

  logic in_req, resp, tmo, accept, busy_evt, fail_evt, rd_ok;

  assign in_req   = (state_ff == REQ);
  assign resp     = in_req & dm.dm2dmi_resp_i;
  assign tmo      = in_req & ~resp & (TIMEOUT != 0) & (cnt_ff == CNT_LAST);
  assign accept   = dmi_update & ~in_req & (stat_ff == OK) & ((upd_op == RD) | (upd_op == WR));
  assign busy_evt = in_req & (dmi_capture | dmi_update);
  assign fail_evt = (resp & dm.dm2dmi_err_i) | tmo;
  assign rd_ok    = resp & ~dm.dm2dmi_err_i & ~wr_ff & ~dmihardreset;

  always_comb begin
    state_next = state_ff;
    case (state_ff)
      IDLE:    if (accept) state_next = REQ;
      REQ:     if (resp | tmo) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (dmihardreset) state_next = IDLE;
  end

  // Status is sticky: only a clear status can be raised, busy taking precedence.
  always_comb begin
    stat_next = stat_ff;
    if (stat_ff == OK) begin
      if (busy_evt)                      stat_next = BUSY;
      else if (fail_evt & ~dmihardreset) stat_next = FAILED;
    end
    if (dmireset | dmihardreset) stat_next = OK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_ff <= IDLE;
      stat_ff  <= OK;
      cnt_ff   <= '0;
      wr_ff    <= 1'b0;
      addr_ff  <= '0;
      wdata_ff <= '0;
      rdata_ff <= '0;
    end else begin
      state_ff <= state_next;
      stat_ff  <= stat_next;
      cnt_ff   <= (in_req && state_next == REQ) ? cnt_ff + 1'b1 : '0;
      if (accept) begin
        wr_ff    <= (upd_op == WR);
        addr_ff  <= upd_addr;
        wdata_ff <= upd_data;
      end
      if (rd_ok) rdata_ff <= dm.dm2dmi_rdata_i;
    end
  end

  assign dm.dmi2dm_req_o   = in_req;
  assign dm.dmi2dm_wr_o    = wr_ff;
  assign dm.dmi2dm_addr_o  = addr_ff;
  assign dm.dmi2dm_wdata_o = wdata_ff;

  assign state     = state_ff;
  assign dmistat   = stat_ff;
  assign last_addr = addr_ff;
  assign rdata     = rdata_ff;

endmodule

// File: rtl/scr1_dmi_tracker.sv
// DTM data registers (DTMCS and DMI access) with capture/shift/update handling;
// request tracking toward the DM lives in scr1_dmi_req_fsm.
module scr1_dmi_tracker
  import scr1_dmi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDLE_HINT  = 1,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tapcsync2dmi_ch_sel_i,
  input  logic [1:0]         tapcsync2dmi_ch_id_i,
  input  logic               tapcsync2dmi_ch_capture_i,
  input  logic               tapcsync2dmi_ch_shift_i,
  input  logic               tapcsync2dmi_ch_update_i,
  input  logic               tapcsync2dmi_ch_tdi_i,
  output logic               dmi2tapcsync_ch_tdo_o,
  scr1_dmi_tracker_if.master dmi2dm,
  output type_scr1_dmi_fsm_e dmi_fsm_state
);

  localparam int unsigned DR_W = ADDR_WIDTH + DATA_WIDTH + 2;

  logic [DR_W-1:0]       dr_ff, dr_next;
  logic [DTMCS_W-1:0]    dtmcs_word;
  logic [1:0]            dmistat;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  dtmcs_sel, dmi_sel, in_req;

  assign dtmcs_sel = tapcsync2dmi_ch_sel_i & (tapcsync2dmi_ch_id_i == DTMCS);
  assign dmi_sel   = tapcsync2dmi_ch_sel_i & (tapcsync2dmi_ch_id_i == DMI);
  assign in_req    = (dmi_fsm_state == REQ);

  always_comb begin
    dtmcs_word = '0;
    dtmcs_word[DTMCS_VERSION_LSB +: 4] = 4'd1;
    dtmcs_word[DTMCS_ABITS_LSB +: 6]   = 6'(ADDR_WIDTH);
    dtmcs_word[DTMCS_STAT_LSB +: 2]    = dmistat;
    dtmcs_word[DTMCS_IDLE_LSB +: 3]    = 3'(IDLE_HINT);

    dr_next = dr_ff;
    if (dtmcs_sel && tapcsync2dmi_ch_capture_i) begin
      dr_next = DR_W'(dtmcs_word);
    end else if (dmi_sel && tapcsync2dmi_ch_capture_i) begin
      // A capture while a request is outstanding reports busy in the op field.
      dr_next = {last_addr, rdata, in_req ? 2'b11 : dmistat};
    end else if (dtmcs_sel && tapcsync2dmi_ch_shift_i) begin
      dr_next = '0;
      dr_next[DTMCS_W-1:0] = {tapcsync2dmi_ch_tdi_i, dr_ff[DTMCS_W-1:1]};
    end else if (dmi_sel && tapcsync2dmi_ch_shift_i) begin
      dr_next = {tapcsync2dmi_ch_tdi_i, dr_ff[DR_W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) dr_ff <= '0;
    else     dr_ff <= dr_next;
  end

  assign dmi2tapcsync_ch_tdo_o = dr_ff[0];

  scr1_dmi_req_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .TIMEOUT    (TIMEOUT)
  ) u_req_fsm (
    .clk          (clk),
    .rst          (rst),
    .dm           (dmi2dm),
    .dmi_capture  (dmi_sel & tapcsync2dmi_ch_capture_i),
    .dmi_update   (dmi_sel & tapcsync2dmi_ch_update_i),
    .upd_op       (type_scr1_dmi_op_e'(dr_ff[1:0])),
    .upd_addr     (dr_ff[DR_W-1 -: ADDR_WIDTH]),
    .upd_data     (dr_ff[DATA_WIDTH+1:2]),
    .dmireset     (dtmcs_sel & tapcsync2dmi_ch_update_i & dr_ff[DTMCS_DMIRESET_BIT]),
    .dmihardreset (dtmcs_sel & tapcsync2dmi_ch_update_i & dr_ff[DTMCS_HARDRESET_BIT]),
    .state        (dmi_fsm_state),
    .dmistat      (dmistat),
    .last_addr    (last_addr),
    .rdata        (rdata)
  );

endmodule

// File: tb/tb_scr1_dmi_tracker.sv
// Bench for scr1_dmi_tracker: directed scenarios plus randomized DMI traffic
// checked against a transaction-level model of the DTM.
module tb_scr1_dmi_tracker;
  import scr1_dmi_pkg::*;

  localparam int AW  = 7;
  localparam int DW  = 32;
  localparam int TMO = 4;
  localparam int DRW = AW + DW + 2;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b1, capture = 1'b0, shift = 1'b0, update = 1'b0, tdi = 1'b0;
  logic [1:0] ch_id = 2'd0;
  logic tdo;
  type_scr1_dmi_fsm_e fsm_state;

  scr1_dmi_tracker_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dm_bus ();

  scr1_dmi_tracker #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IDLE_HINT(1), .TIMEOUT(TMO)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .tapcsync2dmi_ch_sel_i     (sel),
    .tapcsync2dmi_ch_id_i      (ch_id),
    .tapcsync2dmi_ch_capture_i (capture),
    .tapcsync2dmi_ch_shift_i   (shift),
    .tapcsync2dmi_ch_update_i  (update),
    .tapcsync2dmi_ch_tdi_i     (tdi),
    .dmi2tapcsync_ch_tdo_o     (tdo),
    .dmi2dm                    (dm_bus),
    .dmi_fsm_state             (fsm_state)
  );

  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  logic [1:0]    m_stat;
  logic [DW-1:0] m_rdata;
  logic [AW-1:0] m_last_addr;
  logic [DW-1:0] m_wdata;
  logic          m_wr;
  logic          m_req;

  logic [DRW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bus(input string tag);
    check({tag, ".req"},   dm_bus.dmi2dm_req_o, m_req);
    check({tag, ".state"}, fsm_state == REQ, m_req);
    check({tag, ".wr"},    dm_bus.dmi2dm_wr_o, m_wr);
    check({tag, ".addr"},  dm_bus.dmi2dm_addr_o, m_last_addr);
    check({tag, ".wdata"}, dm_bus.dmi2dm_wdata_o, m_wdata);
  endtask

  task automatic mark_fail();
    if (m_stat == 2'd0) m_stat = 2'd2;
  endtask

  task automatic model_reset();
    m_stat = 0; m_rdata = 0; m_last_addr = 0; m_wdata = 0; m_wr = 0; m_req = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- TAP driver tasks ----------------
  task automatic do_capture(input logic [1:0] id);
    ch_id = id; capture = 1'b1;
    tick();
    capture = 1'b0;
  endtask

  task automatic do_shift(input int n, input logic [DRW-1:0] din, output logic [DRW-1:0] dout);
    dout = '0;
    for (int i = 0; i < n; i++) begin
      dout[i] = tdo;
      shift = 1'b1; tdi = din[i];
      tick();
    end
    shift = 1'b0; tdi = 1'b0;
  endtask

  task automatic do_update(input logic [1:0] id);
    ch_id = id; update = 1'b1;
    tick();
    update = 1'b0;
  endtask

  // DTMCS scan; rst_bits = {dmihardreset, dmireset} written on update.
  task automatic dtmcs_scan(input logic [1:0] rst_bits);
    logic [DRW-1:0] din, got;
    din = DRW'($urandom);
    din[16] = rst_bits[0];
    din[17] = rst_bits[1];
    exp_q.push_back(DRW'({14'b0, 2'b0, 1'b0, 3'd1, m_stat, 6'(AW), 4'd1}));
    do_capture(2'd1);
    do_shift(32, din, got);
    check("dtmcs_capture", got, exp_q.pop_front());
    do_update(2'd1);
    if (rst_bits != 2'b00) m_stat = 2'd0;
  endtask

  // DMI scan + update in IDLE; reports whether the model expects a new request.
  task automatic dmi_issue(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [1:0] op, output bit acc);
    logic [DRW-1:0] got;
    exp_q.push_back({m_last_addr, m_rdata, m_stat});
    do_capture(2'd2);
    do_shift(DRW, {addr, data, op}, got);
    check("dmi_capture", got, exp_q.pop_front());
    do_update(2'd2);
    acc = (m_stat == 2'd0) && (op == 2'd1 || op == 2'd2);
    if (acc) begin
      m_req = 1'b1; m_wr = (op == 2'd2); m_last_addr = addr; m_wdata = data;
    end
    check_bus("after_update");
  endtask

  // DM responder: response strobe lat cycles after the accepting update
  // (lat > TMO means no response); 'elapsed' cycles have already passed.
  task automatic respond(input int lat, input int elapsed, input bit e, input logic [DW-1:0] rd);
    int d;
    d = (lat < TMO) ? lat : TMO;
    for (int k = elapsed + 1; k <= d; k++) begin
      if (k == lat) begin
        dm_bus.dm2dmi_resp_i = 1'b1; dm_bus.dm2dmi_err_i = e; dm_bus.dm2dmi_rdata_i = rd;
      end
      tick();
      dm_bus.dm2dmi_resp_i = 1'b0;
      dm_bus.dm2dmi_err_i  = 1'($urandom);
      dm_bus.dm2dmi_rdata_i = $urandom;
      if (k == d) begin
        m_req = 1'b0;
        if (lat <= TMO) begin
          if (e) mark_fail();
          else if (!m_wr) m_rdata = rd;
        end else begin
          mark_fail();
        end
      end
      check_bus("respond");
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit acc, e;
    logic [DRW-1:0] got, busy_word;
    logic [1:0] op;

    dm_bus.dm2dmi_resp_i = 1'b0;
    dm_bus.dm2dmi_err_i = 1'b0;
    dm_bus.dm2dmi_rdata_i = '0;
    model_reset();
    tick();
    do_reset();
    check_bus("reset");
    check("reset.tdo", tdo, 1'b0);

    dtmcs_scan(2'b00);

    // Write with a 3-cycle DM latency, then read returning 0x12345678.
    dmi_issue(7'h10, 32'hDEADBEEF, 2'd2, acc);
    respond(3, 0, 1'b0, 32'h0);
    dmi_issue(7'h22, $urandom, 2'd1, acc);
    respond(2, 0, 1'b0, 32'h12345678);
    dmi_issue(7'h00, 32'h0, 2'd0, acc);

    // Error response, ignored follow-up op, dmireset.
    dmi_issue(7'h05, $urandom, 2'd1, acc);
    respond(1, 0, 1'b1, $urandom);
    dmi_issue(7'h06, $urandom, 2'd2, acc);
    dtmcs_scan(2'b01);

    // Timeout, then clear with dmihardreset from IDLE.
    dmi_issue(7'h07, $urandom, 2'd1, acc);
    respond(TMO + 2, 0, 1'b0, $urandom);
    dmi_issue(7'h08, $urandom, 2'd1, acc);
    dtmcs_scan(2'b10);

    // Response in the very cycle the timeout would fire.
    dmi_issue(7'h09, $urandom, 2'd1, acc);
    respond(TMO, 0, 1'b0, 32'hCAFEF00D);

    // Capture during REQ reports busy; a later update is ignored.
    dmi_issue(7'h31, $urandom, 2'd1, acc);
    busy_word = {m_last_addr, m_rdata, 2'b11};
    do_capture(2'd2);
    m_stat = 2'd3;
    check_bus("busy_capture");
    respond(3, 1, 1'b0, 32'h0BADCAFE);
    exp_q.push_back(busy_word);
    do_shift(DRW, {7'h32, 32'h11112222, 2'b10}, got);
    check("busy_shift_out", got, exp_q.pop_front());
    do_update(2'd2);
    check_bus("busy_update_ignored");
    dtmcs_scan(2'b01);
    dtmcs_scan(2'b00);

    // Update and response in the same cycle: counts as busy.
    dmi_issue(7'h41, $urandom, 2'd2, acc);
    update = 1'b1;
    dm_bus.dm2dmi_resp_i = 1'b1; dm_bus.dm2dmi_err_i = 1'b0;
    tick();
    update = 1'b0; dm_bus.dm2dmi_resp_i = 1'b0;
    m_req = 1'b0; m_stat = 2'd3;
    check_bus("upd_resp_same");
    dtmcs_scan(2'b01);

    // Hardreset with a same-cycle response; DR bit 17 is data[15] of the DMI word.
    dmi_issue(7'h55, 32'h0000_8000, 2'd1, acc);
    ch_id = 2'd1; update = 1'b1;
    dm_bus.dm2dmi_resp_i = 1'b1; dm_bus.dm2dmi_err_i = 1'b0; dm_bus.dm2dmi_rdata_i = 32'hA5A5A5A5;
    tick();
    update = 1'b0; dm_bus.dm2dmi_resp_i = 1'b0;
    m_req = 1'b0; m_stat = 2'd0;
    check_bus("hardreset");
    dmi_issue(7'h00, 32'h0, 2'd0, acc);

    // Reset mid-request.
    dmi_issue(7'h66, $urandom, 2'd2, acc);
    do_reset();
    check_bus("mid_req_reset");
    check("mid_req_reset.tdo", tdo, 1'b0);
    dmi_issue(7'h00, 32'h0, 2'd0, acc);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      op = 2'($urandom_range(0, 3));
      dmi_issue(7'($urandom), $urandom, op, acc);
      if (acc) begin
        e = ($urandom_range(0, 3) == 0);
        respond($urandom_range(1, TMO + 2), 0, e, $urandom);
      end
      if (m_stat != 2'd0 && $urandom_range(0, 1) == 1)
        dtmcs_scan(2'($urandom_range(1, 3)));
      else if ($urandom_range(0, 5) == 0)
        dtmcs_scan(2'b00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scr1_dmi_tracker.md
# scr1_dmi_tracker

Parametrised Debug Module Interface (DMI) with request tracking, for the SCR1 debug subsystem between the TAP controller synchroniser and the Debug Module (DM). It provides the DTMCS and DMI-access data registers. It also runs a held request/response handshake toward the DM, so a DM may take any number of cycles to respond. It keeps a sticky `dmistat` status, supports `dmireset` and `dmihardreset`, and aborts a request on a configurable timeout.

## Interface
Parameters:
- `ADDR_WIDTH`, 7: DMI address bits. Also reported in DTMCS `abits`.
- `DATA_WIDTH`, 32: DMI data bits.
- `IDLE_HINT`, 1: value reported in DTMCS `idle[14:12]`. Range 0..7.
- `TIMEOUT`, 256: maximum DM response wait in cycles. 0 disables the timeout.

Ports:
- `clk` in 1: unit clock.
- `rst` in 1: synchronous, active-high reset.
- `tapcsync2dmi_ch_sel_i` in 1: DTM chain selected.
- `tapcsync2dmi_ch_id_i` in 2: chain ID. 1 = DTMCS, 2 = DMI access.
- `tapcsync2dmi_ch_capture_i` in 1: capture-DR strobe.
- `tapcsync2dmi_ch_shift_i` in 1: shift-DR strobe.
- `tapcsync2dmi_ch_update_i` in 1: update-DR strobe.
- `tapcsync2dmi_ch_tdi_i` in 1: serial data in.
- `dmi2tapcsync_ch_tdo_o` out 1: serial data out, equal to `dr_ff[0]`.
- `dmi2dm_req_o` out 1: request, held until response.
- `dmi2dm_wr_o` out 1: 1 = write, 0 = read.
- `dmi2dm_addr_o` out ADDR_WIDTH: request address.
- `dmi2dm_wdata_o` out DATA_WIDTH: write data.
- `dm2dmi_resp_i` in 1: response strobe, valid only while `req_o` = 1.
- `dm2dmi_err_i` in 1: response carries an error. Qualified by `resp_i`.
- `dm2dmi_rdata_i` in DATA_WIDTH: read data. Qualified by `resp_i` with `wr_o` = 0.

## Operation
Data register:
- `dr_ff` is DR_W = ADDR_WIDTH + DATA_WIDTH + 2 bits. DMI-access layout is {addr, data, op}.

Capture:
- **DTMCS capture:** loads {14'b0, 2'b0, 1'b0, IDLE_HINT, dmistat, ADDR_WIDTH[5:0], 4'd1}.
- **DMI capture, IDLE:** loads {last_addr, rdata_ff, dmistat}.
- **DMI capture, REQ:** loads {last_addr, rdata_ff, 2'b11} and sets `dmistat` to 3 (busy).

Shift:
- **DTMCS:** shifts right within bits [31:0], with `tdi` entering bit 31. Bits above 31 are forced to 0.
- **DMI:** shifts right across the full DR_W, with `tdi` entering the MSB.
- Capture has priority over shift.

Update on DMI (`sel` & id == 2):
- `dmistat` != 0: the op is ignored.
- State REQ: the op is ignored and `dmistat` becomes 3.
- Op 01 (read) or 10 (write): latch addr, wdata and wr, then go to REQ.
- Op 00 or 11: no action.

Update on DTMCS (`sel` & id == 1):
- Bit 16 (`dmireset`) clears `dmistat`.
- Bit 17 (`dmihardreset`) clears `dmistat`, deasserts `req_o`, returns the FSM to IDLE and discards any in-flight response.

FSM states:
- **IDLE:** `req_o` = 0. Moves to REQ on an accepted update.
- **REQ:** `req_o` = 1. The timeout counter increments each cycle.
  - On `resp_i`, return to IDLE. If `err_i` = 1, set `dmistat` to 2. Otherwise, on a read, load `rdata_ff` from `dm2dmi_rdata_i`.
  - If the counter reaches TIMEOUT (TIMEOUT != 0) without a response, set `dmistat` to 2 and return to IDLE.

`dmistat` rules:
- Sticky. Cleared only by reset, `dmireset` or `dmihardreset`.
- Once non-zero, a lower value never overwrites it. Busy (3) overrides failed (2) only when `dmistat` = 0.

Same-cycle events (all decisions use pre-edge state):
- Response and DMI capture/update together: counts as pending, so busy.
- Hardreset and response together: hardreset wins and the response is dropped.
- Timeout and response together: the response wins.

Reset:
- `tdo`, `req_o`, `wr_o`, `addr_o`, `wdata_o`, `dr_ff`, `rdata_ff`, `last_addr`, `dmistat` and the counter all clear to 0. The FSM goes to IDLE.
- A reset mid-request deasserts `req_o` the next cycle. No response is recorded.

## Timing
- All outputs are registered. DM outputs are stable throughout REQ.
- Update accepted at cycle N: `req_o` = 1 from N+1.
- `resp_i` at cycle M: `req_o` = 0, `rdata_ff` and `dmistat` updated from M+1. The fastest response is at N+1.
- A new request can be accepted at the first update in IDLE, with no idle gap needed.
- Timeout: `req_o` drops at N+1+TIMEOUT.
- TDO: capture/shift at cycle K makes `tdo` reflect the new `dr_ff[0]` from K+1.

## Structure
- Shared package `scr1_dmi_pkg`:
  - `type_scr1_dmi_stat_e` with values OK = 0, FAILED = 2, BUSY = 3.
  - `type_scr1_dmi_op_e` with values NOP, RD, WR, RSV.
  - Chain-ID constants DTMCS = 1 and DMI = 2.
  - DTMCS bit-position constants.
- Sub-module `scr1_dmi_req_fsm` holds the IDLE/REQ FSM, the timeout counter, the request registers and the `dmistat` update logic.
- The top level holds the DR, capture mux and shift logic.

## Test plan
- **Write:** shift DMI {addr 0x10, data 0xDEADBEEF, op 10}, then update; DM responds after 3 cycles -> `req_o` high 3 cycles, `wr_o` = 1, `addr_o` = 0x10, `wdata_o` = 0xDEADBEEF; next DMI capture op field = 0.
- **Read:** DM returns 0x12345678 -> next DMI capture shifts out data 0x12345678, op 0.
- **Busy:** DMI capture during REQ, then a new update -> op field 3, second op not issued; DTMCS `dmistat` = 3 until `dmireset`, then 0.
- **Error and timeout:** `resp_i` with `err_i` -> `dmistat` = 2; with TIMEOUT = 4 and no response -> `req_o` drops at N+5, `dmistat` = 2; a later op is ignored until `dmireset`.
- **Hardreset:** `dmihardreset` during REQ, with `resp_i` in the same cycle -> `req_o` = 0 next cycle, `rdata_ff` unchanged, `dmistat` = 0.
- **DTMCS readout and reset:** ADDR_WIDTH = 7, IDLE_HINT = 1 -> captured DTMCS = 0x00001071; `rst` asserted mid-REQ -> all outputs 0 next cycle.
